// File: rtl/quad_counter_gen_if.sv
// Signal bundle between the quadrature counter and its controller / register file.
// The controller holds the master modport; the counter holds the slave modport.
interface quad_counter_gen_if #(
    parameter int unsigned WIDTH = 16
);
    logic             filterce;
    logic [1:0]       tach;
    logic             index;
    logic             invphase;
    logic [1:0]       mode;
    logic             freeze;
    logic             clear;
    logic             preload_en;
    logic [WIDTH-1:0] preload_val;
    logic             latch;
    logic             idx_en;
    logic             err_clr;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] snapshot;
    logic [WIDTH-1:0] idx_cap;
    logic             idx_valid;
    logic             dir;
    logic             ovf;
    logic             unf;
    logic             err;

    modport master (
        output filterce, tach, index, invphase, mode, freeze, clear, preload_en,
               preload_val, latch, idx_en, err_clr,
        input  count, snapshot, idx_cap, idx_valid, dir, ovf, unf, err
    );

    modport slave (
        input  filterce, tach, index, invphase, mode, freeze, clear, preload_en,
               preload_val, latch, idx_en, err_clr,
        output count, snapshot, idx_cap, idx_valid, dir, ovf, unf, err
    );
endinterface

// File: rtl/quad_counter_gen.sv
// Quadrature encoder counter: sync + glitch filter on A/B/index, x1/x2/x4 decode,
// up/down position count with clear/preload, wrap pulses, snapshot and index capture.
module quad_counter_gen #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FILT_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    quad_counter_gen_if.slave qc
);
    // Bit order for all conditioning stages: 0 = A, 1 = B, 2 = index.
    logic [2:0]                 r_sync1, r_sync2, r_filt;
    logic [2:0][FILT_DEPTH-1:0] r_taps;

    logic [1:0]       r_last;
    logic             r_idx_last, r_idx_pulse;
    logic             r_step_up, r_step_dn;
    logic             r_err;
    logic [WIDTH-1:0] r_count, r_snapshot, r_idx_cap;
    logic             r_idx_valid, r_dir, r_ovf, r_unf;

    logic [1:0] w_ba;
    logic       w_changed, w_illegal, w_fwd, w_a_chg;
    logic       w_step_up, w_step_dn;
    logic       w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_taps  <= '0;
            r_filt  <= '0;
        end else begin
            r_sync1 <= {qc.index, qc.tach};
            r_sync2 <= r_sync1;
            for (int k = 0; k < 3; k++) begin
                if (qc.filterce) begin
                    r_taps[k] <= {r_taps[k][FILT_DEPTH-2:0], r_sync2[k]};
                end
                if (&r_taps[k]) begin
                    r_filt[k] <= 1'b1;
                end else if (~|r_taps[k]) begin
                    r_filt[k] <= 1'b0;
                end
            end
        end
    end

    assign w_ba      = qc.invphase ? {r_filt[0], r_filt[1]} : {r_filt[1], r_filt[0]};
    assign w_changed = (w_ba != r_last);
    assign w_illegal = &(w_ba ^ r_last);
    // For a single-bit Gray step, forward (00->01->11->10) is exactly last.B != new.A.
    assign w_fwd     = r_last[1] ^ w_ba[0];
    assign w_a_chg   = (w_ba[0] != r_last[0]);

    always_comb begin
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        if (w_changed && !w_illegal && !qc.freeze) begin
            unique case (qc.mode)
                2'b01: begin
                    w_step_up = w_a_chg & w_fwd;
                    w_step_dn = w_a_chg & ~w_fwd;
                end
                2'b10: begin
                    w_step_up = (r_last == 2'b10) && (w_ba == 2'b00);
                    w_step_dn = (r_last == 2'b00) && (w_ba == 2'b10);
                end
                default: begin
                    w_step_up = w_fwd;
                    w_step_dn = ~w_fwd;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= '0;
            r_step_up   <= 1'b0;
            r_step_dn   <= 1'b0;
            r_err       <= 1'b0;
            r_idx_last  <= 1'b0;
            r_idx_pulse <= 1'b0;
        end else begin
            r_last      <= w_ba;
            r_step_up   <= w_step_up;
            r_step_dn   <= w_step_dn;
            r_idx_last  <= r_filt[2];
            r_idx_pulse <= r_filt[2] & ~r_idx_last;
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (qc.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign w_capture = r_idx_pulse & qc.idx_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_snapshot  <= '0;
            r_idx_cap   <= '0;
            r_idx_valid <= 1'b0;
            r_dir       <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            if (qc.clear) begin
                r_count <= '0;
            end else if (qc.preload_en) begin
                r_count <= qc.preload_val;
            end else if (r_step_up) begin
                r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
                r_dir   <= 1'b1;
                r_ovf   <= (r_count == {WIDTH{1'b1}});
            end else if (r_step_dn) begin
                r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
                r_dir   <= 1'b0;
                r_unf   <= (r_count == '0);
            end
            if (qc.latch) begin
                r_snapshot <= r_count;
            end
            // Capture outranks latch for idx_valid when both land on one edge.
            if (w_capture) begin
                r_idx_cap   <= r_count;
                r_idx_valid <= 1'b1;
            end else if (qc.latch) begin
                r_idx_valid <= 1'b0;
            end
        end
    end

    assign qc.count     = r_count;
    assign qc.snapshot  = r_snapshot;
    assign qc.idx_cap   = r_idx_cap;
    assign qc.idx_valid = r_idx_valid;
    assign qc.dir       = r_dir;
    assign qc.ovf       = r_ovf;
    assign qc.unf       = r_unf;
    assign qc.err       = r_err;
endmodule

// File: tb/tb_quad_counter_gen.sv
// Directed bench for quad_counter_gen (WIDTH=16, FILT_DEPTH=4, filterce held high).
module tb_quad_counter_gen;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    quad_counter_gen_if #(.WIDTH(16)) qc ();

    quad_counter_gen #(.WIDTH(16), .FILT_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .qc    (qc)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic move(input logic [1:0] ba);
        qc.tach = ba;
        tick(10);
    endtask

    task automatic fwd_cycle();
        move(2'b01);
        move(2'b11);
        move(2'b10);
        move(2'b00);
    endtask

    task automatic pulse_preload(input logic [15:0] v);
        qc.preload_val = v;
        qc.preload_en  = 1'b1;
        tick(1);
        qc.preload_en  = 1'b0;
    endtask

    task automatic pulse_clear();
        qc.clear = 1'b1;
        tick(1);
        qc.clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"}, 32'(qc.count), 0);
        chk({tag, "_snap"}, 32'(qc.snapshot), 0);
        chk({tag, "_icap"}, 32'(qc.idx_cap), 0);
        chk({tag, "_flags"}, 32'({qc.idx_valid, qc.dir, qc.ovf, qc.unf, qc.err}), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        qc.filterce    = 1'b1;
        qc.tach        = 2'b00;
        qc.index       = 1'b0;
        qc.invphase    = 1'b0;
        qc.mode        = 2'b00;
        qc.freeze      = 1'b0;
        qc.clear       = 1'b0;
        qc.preload_en  = 1'b0;
        qc.preload_val = '0;
        qc.latch       = 1'b0;
        qc.idx_en      = 1'b0;
        qc.err_clr     = 1'b0;
        tick(3);
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick(2);

        // Asynchronous reset from a non-zero state, checked before the next edge
        pulse_preload(16'h1234);
        qc.latch = 1'b1;
        tick(1);
        qc.latch = 1'b0;
        chk("pre_rst_count", 32'(qc.count), 32'h1234);
        chk("pre_rst_snap", 32'(qc.snapshot), 32'h1234);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        #2 rst_n = 1'b1;
        tick(2);

        // x4 forward with latency check
        qc.tach = 2'b01;
        tick(8);
        chk("lat_before", 32'(qc.count), 0);
        tick(1);
        chk("lat_at9", 32'(qc.count), 1);
        chk("lat_dir", 32'(qc.dir), 1);
        tick(1);
        move(2'b11); move(2'b10); move(2'b00);
        move(2'b01); move(2'b11); move(2'b10); move(2'b00);
        chk("x4_fwd8", 32'(qc.count), 8);
        chk("x4_fwd_dir", 32'(qc.dir), 1);
        move(2'b10); move(2'b11); move(2'b01);
        chk("x4_rev3", 32'(qc.count), 5);
        chk("x4_rev_dir", 32'(qc.dir), 0);
        move(2'b00);
        pulse_clear();
        chk("clear", 32'(qc.count), 0);

        // Resolution modes, one forward cycle each
        fwd_cycle();
        chk("mode_x4", 32'(qc.count), 4);
        qc.mode = 2'b01;
        fwd_cycle();
        chk("mode_x2", 32'(qc.count), 6);
        qc.mode = 2'b10;
        fwd_cycle();
        chk("mode_x1", 32'(qc.count), 7);
        qc.mode = 2'b11;
        fwd_cycle();
        chk("mode_rsvd", 32'(qc.count), 11);
        qc.invphase = 1'b1;
        qc.mode = 2'b00;
        fwd_cycle();
        chk("inv_x4", 32'(qc.count), 7);
        qc.mode = 2'b01;
        fwd_cycle();
        chk("inv_x2", 32'(qc.count), 5);
        qc.mode = 2'b10;
        fwd_cycle();
        chk("inv_x1", 32'(qc.count), 4);
        chk("inv_dir", 32'(qc.dir), 0);
        qc.invphase = 1'b0;
        qc.mode = 2'b00;

        // Wrap flags
        pulse_preload(16'hFFFF);
        chk("preload", 32'(qc.count), 32'hFFFF);
        qc.tach = 2'b01;
        tick(8);
        chk("ovf_early", 32'({qc.ovf, qc.count}), 32'h0FFFF);
        tick(1);
        chk("ovf_wrap", 32'({qc.ovf, qc.count}), 32'h10000);
        tick(1);
        chk("ovf_1cyc", 32'(qc.ovf), 0);
        qc.tach = 2'b00;
        tick(9);
        chk("unf_wrap", 32'({qc.unf, qc.dir, qc.count}), 32'h2FFFF);
        tick(1);
        chk("unf_1cyc", 32'(qc.unf), 0);
        qc.tach = 2'b01;
        tick(8);
        qc.clear = 1'b1;
        tick(1);
        qc.clear = 1'b0;
        chk("clr_vs_step", 32'({qc.ovf, qc.dir, qc.count}), 0);
        tick(1);
        chk("clr_after", 32'({qc.ovf, qc.unf, qc.count}), 0);
        tick(8);

        // Illegal transitions, error clearing and glitch rejection
        move(2'b00);
        pulse_clear();
        chk("err_none", 32'(qc.err), 0);
        move(2'b11);
        chk("illegal_err", 32'(qc.err), 1);
        chk("illegal_nostep", 32'(qc.count), 0);
        move(2'b10);
        chk("resync_step", 32'({qc.dir, qc.count}), 32'h10001);
        qc.err_clr = 1'b1;
        tick(1);
        qc.err_clr = 1'b0;
        chk("err_clr", 32'(qc.err), 0);
        qc.tach = 2'b00;
        tick(2);
        qc.tach = 2'b10;
        tick(12);
        chk("glitch_cnt", 32'(qc.count), 1);
        chk("glitch_err", 32'(qc.err), 0);
        qc.tach = 2'b01;
        tick(7);
        chk("err_pre", 32'(qc.err), 0);
        qc.err_clr = 1'b1;
        tick(1);
        qc.err_clr = 1'b0;
        chk("err_set_wins", 32'(qc.err), 1);
        tick(2);
        chk("err_sticky", 32'({qc.err, qc.count}), 32'h10001);

        // Index capture and snapshot
        pulse_preload(16'd37);
        qc.idx_en = 1'b1;
        qc.index  = 1'b1;
        tick(8);
        chk("idx_early", 32'(qc.idx_valid), 0);
        tick(1);
        chk("idx_valid", 32'(qc.idx_valid), 1);
        chk("idx_cap", 32'(qc.idx_cap), 37);
        pulse_preload(16'd40);
        qc.latch = 1'b1;
        tick(1);
        qc.latch = 1'b0;
        chk("snap", 32'(qc.snapshot), 40);
        chk("snap_clr_valid", 32'(qc.idx_valid), 0);
        qc.index = 1'b0;
        tick(10);
        pulse_preload(16'd45);
        qc.index = 1'b1;
        tick(8);
        qc.latch = 1'b1;
        tick(1);
        qc.latch = 1'b0;
        chk("cap_vs_latch", 32'(qc.idx_valid), 1);
        chk("cap_vs_latch_cap", 32'(qc.idx_cap), 45);
        chk("cap_vs_latch_snap", 32'(qc.snapshot), 45);

        // Freeze holds count and release adds no step
        qc.freeze = 1'b1;
        move(2'b11);
        move(2'b10);
        chk("freeze_hold", 32'(qc.count), 45);
        qc.freeze = 1'b0;
        tick(10);
        chk("unfreeze", 32'(qc.count), 45);
        move(2'b00);
        chk("post_freeze", 32'({qc.dir, qc.count}), 32'h1002E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/quad_counter_gen.md
# quad_counter_gen

Parametrised quadrature counter: the next-generation replacement for the fixed 16-bit tach counter. It conditions two encoder phases plus an index pulse, decodes them in x1/x2/x4 resolution, and maintains a WIDTH-bit up/down position count. The count supports clear, preload, wrap flags, sticky illegal-transition detection, an atomic snapshot register and index-edge capture. It sits between the tach wheel / linear encoder pins and the motor-control register file.

## Interface
- WIDTH, 16: counter, preload, snapshot and index-capture width (2..32).
- FILT_DEPTH, 4: number of consecutive equal filter samples needed to change a filtered input (2..8).

- clk  in  1  system clock; all logic rises on it.
- rst_n  in  1  reset, asynchronous, active-low; one clock, no other clock domains.
- filterce  in  1  filter sample enable (prescaled strobe).
- tach  in  2  raw encoder phases, asynchronous to clk; tach[0]=A, tach[1]=B.
- index  in  1  raw index pulse, asynchronous to clk.
- invphase  in  1  1 = swap A and B after filtering.
- mode  in  2  00=x4, 01=x2, 10=x1, 11=reserved (treated as x4).
- freeze  in  1  1 = no count steps.
- clear  in  1  synchronous zero of count.
- preload_en  in  1  load count from preload_val.
- preload_val  in  WIDTH  preload value.
- latch  in  1  copy count into snapshot.
- idx_en  in  1  enables index capture.
- err_clr  in  1  clears err.
- count  out  WIDTH  live position.
- snapshot  out  WIDTH  latched position.
- idx_cap  out  WIDTH  count at last index rising edge.
- idx_valid  out  1  sticky, set on capture, cleared by latch.
- dir  out  1  direction of last valid step, 1=up.
- ovf  out  1  one-clock pulse when count wraps all-ones to 0.
- unf  out  1  one-clock pulse when count wraps 0 to all-ones.
- err  out  1  sticky illegal transition flag.

## Operation
- Reset: all registers 0, including synchronisers, filter taps, filtered outputs and decoder last-state. All outputs are 0 on reset.
- Conditioning, applied to A, B and index independently:
  - 2-flop synchroniser, clocked every clk.
  - FILT_DEPTH shift register, advanced only when filterce=1.
  - Filtered output register goes 1 when all taps are 1 and 0 when all taps are 0; otherwise it holds. It updates every clk.
- invphase is applied after filtering to produce {B,A}.
- Decoder holds a last-state register.
- Forward sequence is 00→01→11→10→00, written BA; this is up. The reverse sequence is down.
- Step generation by mode:
  - x4: every valid transition steps.
  - x2: only transitions where A changes step.
  - x1: only 10→00 steps up and only 00→10 steps down.
- Illegal transition (both bits change): no step, err<=1, last-state <= new state (resynchronises).
- No change: no action.
- freeze=1: last-state still tracks the input and err still updates, but no step is issued. Unfreezing therefore never produces a spurious count.
- Counter priority, highest first: clear > preload_en > step.
  - A step updates count ±1 modulo 2^WIDTH and sets dir.
  - ovf/unf pulse in the cycle count takes the wrapped value.
  - clear and preload do not pulse ovf/unf and do not change dir.
- Snapshot: latch=1 → snapshot <= count as it stands before that edge's update, and idx_valid <= 0.
- Index: on a rising edge of filtered index with idx_en=1, idx_cap <= pre-update count and idx_valid <= 1.
  - If latch occurs in the same cycle, the capture wins and idx_valid = 1.
- err: set wins over err_clr in the same cycle.

## Timing
- With filterce held 1, a clean input change is reflected in count at the (FILT_DEPTH+5)th rising clk edge after it. That is 2 synchroniser + FILT_DEPTH taps + 1 filter output + 1 decoder + 1 counter; 9 edges for FILT_DEPTH=4.
- Index path latency to idx_cap is the same as the tach path to count.
- Glitches shorter than FILT_DEPTH filterce samples never reach the decoder.
- clear, preload_en, latch, err_clr and idx_en act at the next clk edge (1-cycle latency) and are level-sampled; a multi-cycle assertion repeats the action.
- Maximum count rate is one step per clk. Encoder edge rate must stay below filterce rate / FILT_DEPTH.
- rst_n deassertion mid-motion: the first filtered state after reset is compared against last-state=00. If that state is 11, err is set.

## Test plan
- Reset: assert rst_n=0 mid-count with count=0x1234 → every output reads 0 immediately, without waiting for a clk edge.
- x4 forward, WIDTH=16, FILT_DEPTH=4, filterce=1: 8 forward transitions, each held 10 clk → count=8, dir=1. First step appears exactly 9 edges after the first change. Then 3 reverse transitions → count=5, dir=0.
- Modes: one full forward cycle (4 transitions) → x4 gives +4, x2 gives +2, x1 gives +1. invphase=1 with the same stimulus → −4/−2/−1.
- Wrap: preload 0xFFFF, one up step → count=0 with a 1-cycle ovf. One down step → count=0xFFFF with unf. clear asserted together with a step → count=0 and no ovf/unf.
- Illegal and filter: 00→11 → err=1, no step, next forward transition from 11 counts normally. A 2-sample glitch is ignored. err_clr together with a new error → err stays 1.
- Index and snapshot: index rising edge at count=37 with idx_en=1 → idx_cap=37, idx_valid=1. latch at count=40 → snapshot=40, idx_valid=0. freeze=1 while stepping → count holds, and on release no extra step occurs.
